lfsr_word_ctrl: RTL and testbench
=================================

LFSR_WORD_CTRL -- requirements
Module: lfsr_word_ctrl

Interface
REQ-001 Parameter LFSR_LENGTH, default 4, LFSR register width (>=2).
REQ-002 Parameter LFSR_TAPS, default 4'b1100, feedback tap mask, width LFSR_LENGTH.
REQ-003 Parameter LFSR_SEED_VAL, default 4'b1011, reset seed and all-zero substitute, nonzero.
REQ-004 Parameter WORD_WIDTH, default 8, bits per output word (2..32).
REQ-005 lfsr_clk  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  reset, asynchronous and active-low.
REQ-007 seed_load  input  1  load seed_val into LFSR, honoured in IDLE only.
REQ-008 seed_val  input  LFSR_LENGTH  seed to load.
REQ-009 cmd_valid  input  1  request to generate cmd_len words.
REQ-010 cmd_ready  output  1  high in IDLE only.
REQ-011 cmd_len  input  8  number of words, 0..255.
REQ-012 abort  input  1  synchronous cancel of the current command.
REQ-013 word_valid  output  1  word_data holds an unaccepted word.
REQ-014 word_ready  input  1  consumer accepts word.
REQ-015 word_data  output  WORD_WIDTH  assembled word, first generated bit in MSB.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on command completion.
REQ-018 lfsr_state_out  output  LFSR_LENGTH  current LFSR register.

Function
REQ-019 LFSR step: fb = XOR-reduce(state AND LFSR_TAPS); out bit = state[MSB]; next state = {state[LFSR_LENGTH-2:0], fb}.
REQ-020 LFSR steps only in RUN, one step per cycle; state held in all other states.
REQ-021 FSM states IDLE, RUN, HOLD, DONE; IDLE after reset.
REQ-022 IDLE: cmd_valid&&cmd_ready -> latch cmd_len as remaining count; remaining>0 -> RUN, remaining==0 -> DONE.
REQ-023 IDLE: seed_load -> LFSR := seed_val next edge; seed_val==0 -> LFSR := LFSR_SEED_VAL; seed_load wins over cmd_valid in same cycle (command not accepted, cmd_ready still high).
REQ-024 RUN: each cycle shift out bit into assembly register LSB-side, bit counter +1; after WORD_WIDTH steps load word_data, set word_valid, decrement remaining, go HOLD.
REQ-025 Latency: first word_valid asserted WORD_WIDTH cycles after the command-accept edge.
REQ-026 HOLD: word_data and word_valid stable until word_valid&&word_ready; then remaining>0 -> RUN, remaining==0 -> DONE.
REQ-027 Throughput: at most one word per WORD_WIDTH+1 cycles; no overlap of assembly and hold.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 abort in RUN/HOLD/DONE: next edge -> IDLE, word_valid=0, partial word discarded, no done pulse, LFSR state retained; abort in IDLE ignored.
REQ-030 abort beats word_ready in the same cycle: word counts as not accepted.
REQ-031 seed_load outside IDLE ignored.
REQ-032 cmd_valid outside IDLE ignored (cmd_ready low).

Reset
REQ-033 resetn low forces immediately: FSM IDLE, LFSR = LFSR_SEED_VAL, word_valid=0, word_data=0, done=0, busy=0, cmd_ready=1 after release, counters 0.
REQ-034 Reset mid-command discards all progress; no done pulse.

Verification
REQ-035 Reset, cmd_len=1, word_ready=1 -> word_valid after 8 cycles, word_data=0xBC, lfsr_state_out=4'b0100, done one cycle after accept.
REQ-036 cmd_len=2, word_ready held low 5 cycles on first word -> word_data 0xBC stable, LFSR frozen at 0100, second word follows after release, done once.
REQ-037 seed_load seed_val=0 in IDLE -> lfsr_state_out=4'b1011; seed_load and cmd_valid same cycle -> command not accepted.
REQ-038 cmd_len=0 -> busy one cycle, done pulse, no word_valid, LFSR unchanged.
REQ-039 abort at RUN step 3 -> IDLE next cycle, no word, no done, lfsr_state_out=4'b1110; next cmd continues from 1110.
REQ-040 resetn low during HOLD -> word_valid=0, busy=0 asynchronously, LFSR=1011.

Source files
------------

// File: rtl/lfsr_word_ctrl.sv
// lfsr_word_ctrl: Fibonacci-style LFSR bit generator that packs LFSR output
// bits into WORD_WIDTH-bit words under a command/handshake controller.
//
// Ports:
//   lfsr_clk        clock, rising edge
//   resetn          asynchronous active-low reset
//   seed_load       load seed_val into the LFSR (IDLE only)
//   seed_val        seed to load; zero selects LFSR_SEED_VAL
//   cmd_valid       request to generate cmd_len words
//   cmd_ready       high in IDLE only
//   cmd_len         number of words to generate (0..255)
//   abort           synchronous cancel of the current command
//   word_valid      word_data holds an unaccepted word
//   word_ready      consumer accepts the word
//   word_data       assembled word, first generated bit in the MSB
//   busy            high in any state other than IDLE
//   done            one-cycle pulse on command completion
//   lfsr_state_out  current LFSR register
module lfsr_word_ctrl #(
    parameter int unsigned                 LFSR_LENGTH   = 4,
    parameter logic [LFSR_LENGTH-1:0]      LFSR_TAPS     = LFSR_LENGTH'(4'b1100),
    parameter logic [LFSR_LENGTH-1:0]      LFSR_SEED_VAL = LFSR_LENGTH'(4'b1011),
    parameter int unsigned                 WORD_WIDTH    = 8
) (
    input  logic                   lfsr_clk,
    input  logic                   resetn,
    input  logic                   seed_load,
    input  logic [LFSR_LENGTH-1:0] seed_val,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_len,
    input  logic                   abort,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [WORD_WIDTH-1:0]  word_data,
    output logic                   busy,
    output logic                   done,
    output logic [LFSR_LENGTH-1:0] lfsr_state_out
);

    localparam int unsigned CNT_W = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [LFSR_LENGTH-1:0] lfsr_q, lfsr_d;
    logic [WORD_WIDTH-1:0]  asm_q, asm_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic                   valid_q, valid_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]             remain_q, remain_d;
    logic                   busy_q, done_q, cmd_ready_q;

    logic                   fb;
    logic [LFSR_LENGTH-1:0] lfsr_next;
    logic                   out_bit;

    // LFSR combinational step
    assign fb        = ^(lfsr_q & LFSR_TAPS);
    assign lfsr_next = {lfsr_q[LFSR_LENGTH-2:0], fb};
    assign out_bit   = lfsr_q[LFSR_LENGTH-1];

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        asm_d     = asm_q;
        word_d    = word_q;
        valid_d   = valid_q;
        bit_cnt_d = bit_cnt_q;
        remain_d  = remain_q;
        case (state_q)
            IDLE: begin
                // seed_load has priority; the command stays pending
                if (seed_load) begin
                    lfsr_d = (seed_val == '0) ? LFSR_SEED_VAL : seed_val;
                end else if (cmd_valid) begin
                    remain_d  = cmd_len;
                    bit_cnt_d = '0;
                    asm_d     = '0;
                    state_d   = (cmd_len != 8'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    lfsr_d = lfsr_next;
                    asm_d  = {asm_q[WORD_WIDTH-2:0], out_bit};
                    if (bit_cnt_q == LAST_BIT) begin
                        word_d    = asm_d;
                        valid_d   = 1'b1;
                        remain_d  = remain_q - 8'd1;
                        bit_cnt_d = '0;
                        state_d   = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // abort wins over a simultaneous word_ready
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (word_ready) begin
                    valid_d = 1'b0;
                    state_d = (remain_q != 8'd0) ? RUN : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge lfsr_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED_VAL;
            asm_q       <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            bit_cnt_q   <= '0;
            remain_q    <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            asm_q       <= asm_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            bit_cnt_q   <= bit_cnt_d;
            remain_q    <= remain_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            cmd_ready_q <= (state_d == IDLE);
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign word_valid     = valid_q;
    assign word_data      = word_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign lfsr_state_out = lfsr_q;

endmodule

// File: tb/tb_lfsr_word_ctrl.sv
// Testbench for lfsr_word_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a word-level behavioural model.
module tb_lfsr_word_ctrl;

    localparam logic [3:0] SEED = 4'b1011;

    logic       lfsr_clk = 1'b0;
    logic       resetn;
    logic       seed_load;
    logic [3:0] seed_val;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic       abort;
    logic       word_valid;
    logic       word_ready;
    logic [7:0] word_data;
    logic       busy;
    logic       done;
    logic [3:0] lfsr_state_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model: phase 0 idle, 1 generating, 2 word offered, 3 done pulse
    int         m_phase;
    int         m_left;
    int         m_steps;
    logic [3:0] m_lfsr;
    logic [3:0] m_start;
    logic [7:0] m_word;

    lfsr_word_ctrl dut (
        .lfsr_clk       (lfsr_clk),
        .resetn         (resetn),
        .seed_load      (seed_load),
        .seed_val       (seed_val),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_len        (cmd_len),
        .abort          (abort),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .word_data      (word_data),
        .busy           (busy),
        .done           (done),
        .lfsr_state_out (lfsr_state_out)
    );

    always #5 lfsr_clk = ~lfsr_clk;

    function automatic logic [3:0] lstep(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // the word produced by WORD_WIDTH steps starting from state s
    function automatic logic [7:0] gen_word(input logic [3:0] s);
        logic [7:0] w = 8'h00;
        logic [3:0] t = s;
        for (int i = 0; i < 8; i++) begin
            w = {w[6:0], t[3]};
            t = lstep(t);
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_steps = 0;
        m_lfsr  = SEED;
        m_start = SEED;
        m_word  = 8'h00;
    endtask

    task automatic model_step();
        case (m_phase)
            0: begin
                if (seed_load) begin
                    m_lfsr = (seed_val == 4'd0) ? SEED : seed_val;
                end else if (cmd_valid) begin
                    m_left  = int'(cmd_len);
                    m_steps = 0;
                    m_start = m_lfsr;
                    m_phase = (cmd_len != 8'd0) ? 1 : 3;
                end
            end
            1: begin
                if (abort) m_phase = 0;
                else begin
                    m_lfsr = lstep(m_lfsr);
                    m_steps++;
                    if (m_steps == 8) begin
                        m_word  = gen_word(m_start);
                        m_left--;
                        m_phase = 2;
                    end
                end
            end
            2: begin
                if (abort) m_phase = 0;
                else if (word_ready) begin
                    if (m_left > 0) begin
                        m_phase = 1;
                        m_steps = 0;
                        m_start = m_lfsr;
                    end else begin
                        m_phase = 3;
                    end
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // per-cycle comparison against the model
    always @(negedge lfsr_clk) begin
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("done", 32'(done), 32'(m_phase == 3));
            check("word_valid", 32'(word_valid), 32'(m_phase == 2));
            check("lfsr_state", 32'(lfsr_state_out), 32'(m_lfsr));
            if (m_phase == 2) check("word_data", 32'(word_data), 32'(m_word));
        end
    end

    task automatic idle_inputs();
        seed_load  = 1'b0;
        seed_val   = 4'd0;
        cmd_valid  = 1'b0;
        cmd_len    = 8'd0;
        abort      = 1'b0;
        word_ready = 1'b0;
    endtask

    // one clock: DUT and model advance on the same edge
    task automatic cyc();
        @(posedge lfsr_clk);
        model_step();
        @(negedge lfsr_clk);
    endtask

    task automatic do_reset();
        @(negedge lfsr_clk);
        #1;
        chk_en = 1'b0;
        idle_inputs();
        resetn = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_data", 32'(word_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lfsr", 32'(lfsr_state_out), 32'(SEED));
        @(negedge lfsr_clk);
        resetn = 1'b1;
        model_reset();
        #1;
        chk_en = 1'b1;
        @(negedge lfsr_clk);
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic rdy);
        cmd_valid  = 1'b1;
        cmd_len    = len;
        word_ready = rdy;
        cyc();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!word_valid && n < budget) begin
            cyc();
            n++;
        end
        if (!word_valid) check("wait_valid_timeout", 32'(n), 32'(budget + 1));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cyc();
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    int lat;
    int r;

    initial begin
        resetn = 1'b1;
        idle_inputs();
        model_reset();

        check("model_word_pin", 32'(gen_word(SEED)), 32'h0000_00BC);

        // single word, consumer always ready
        do_reset();
        send_cmd(8'd1, 1'b1);
        wait_valid(20, lat);
        check("latency", 32'(lat), 32'd8);
        check("word_bc", 32'(word_data), 32'h0000_00BC);
        check("lfsr_0100", 32'(lfsr_state_out), 32'h4);
        cyc();
        check("done_pulse", 32'(done), 32'd1);
        cyc();
        check("done_cleared", 32'(done), 32'd0);

        // two words with back-pressure on the first
        do_reset();
        send_cmd(8'd2, 1'b0);
        wait_valid(20, lat);
        for (int i = 0; i < 5; i++) cyc();
        check("hold_word", 32'(word_data), 32'h0000_00BC);
        check("hold_lfsr", 32'(lfsr_state_out), 32'h4);
        word_ready = 1'b1;
        cyc();
        word_ready = 1'b0;
        wait_valid(20, lat);
        check("second_latency", 32'(lat), 32'd8);
        check("second_word", 32'(word_data), 32'(gen_word(4'b0100)));
        word_ready = 1'b1;
        wait_idle(10);

        // seed loads and seed/command collision
        do_reset();
        seed_load = 1'b1;
        seed_val  = 4'b0110;
        cyc();
        check("seed_0110", 32'(lfsr_state_out), 32'h6);
        seed_val  = 4'd0;
        cyc();
        check("seed_zero", 32'(lfsr_state_out), 32'(SEED));
        cmd_valid = 1'b1;
        cmd_len   = 8'd3;
        cyc();
        seed_load = 1'b0;
        cmd_valid = 1'b0;
        check("collide_busy", 32'(busy), 32'd0);
        check("collide_ready", 32'(cmd_ready), 32'd1);

        // zero-length command
        send_cmd(8'd0, 1'b0);
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_done", 32'(done), 32'd1);
        cyc();
        check("len0_idle", 32'(busy), 32'd0);
        check("len0_lfsr", 32'(lfsr_state_out), 32'(SEED));

        // abort after three steps, then resume from the retained state
        do_reset();
        send_cmd(8'd1, 1'b1);
        for (int i = 0; i < 3; i++) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_lfsr", 32'(lfsr_state_out), 32'hE);
        send_cmd(8'd1, 1'b1);
        wait_valid(20, lat);
        check("resume_word", 32'(word_data), 32'(gen_word(4'b1110)));
        wait_idle(10);

        // asynchronous reset while a word is being held
        do_reset();
        send_cmd(8'd1, 1'b0);
        wait_valid(20, lat);
        #2;
        chk_en = 1'b0;
        resetn = 1'b0;
        #1;
        check("async_valid", 32'(word_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_lfsr", 32'(lfsr_state_out), 32'(SEED));
        @(negedge lfsr_clk);
        idle_inputs();
        resetn = 1'b1;
        model_reset();
        #1;
        chk_en = 1'b1;
        @(negedge lfsr_clk);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            seed_load  = ($urandom_range(0, 99) < 5);
            seed_val   = 4'($urandom_range(0, 15));
            cmd_valid  = ($urandom_range(0, 99) < 30);
            r          = int'($urandom_range(0, 99));
            cmd_len    = (r < 10) ? 8'd0 :
                         (r < 90) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(4, 20));
            abort      = ($urandom_range(0, 99) < 2);
            word_ready = ($urandom_range(0, 99) < 60);
            cyc();
        end
        idle_inputs();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
